// File: rtl/peak_window_ctrl_pkg.sv
// Shared definitions for the histogram peak finder and its window sequencer.
package peak_window_ctrl_pkg;

  // Cycles from the last enabled sample edge until the peak finder's max
  // output reflects it (1 counter stage + 4 compare stages).
  localparam int PEAK_PIPE_LAT = 5;
  // Bin counter width of the peak finder; a window never exceeds it.
  localparam int HIST_CNT_DW   = 13;
  // Width of a histogram bin index.
  localparam int BIN_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    SETTLE,
    FETCH,
    OUTPUT,
    FLUSH
  } state_e;

endpackage

// File: rtl/peak_window_ctrl.sv
// Window sequencer for the 4-bit histogram peak finder: gates count enable
// for a programmed number of samples, waits out the compare pipeline, reads
// the peak bin (which also clears the histogram) and offers it downstream.
module peak_window_ctrl
  import peak_window_ctrl_pkg::*;
#(
  parameter int CNT_DW   = HIST_CNT_DW,
  parameter int PIPE_LAT = PEAK_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_DW-1:0] cfg_num_samples,
  input  logic              sample_valid,
  output logic              cnt_en,
  output logic              peak_ready,
  input  logic              peak_valid,
  input  logic [BIN_W-1:0]  peak_bin,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [BIN_W-1:0]  res_bin,
  output logic              busy,
  output logic              cfg_err
);

  localparam int               SET_W    = $clog2(PIPE_LAT + 1);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(PIPE_LAT - 1);
  // In FLUSH the settle counter parks here once the pipeline has drained.
  localparam logic [SET_W-1:0] SET_DONE = SET_W'(PIPE_LAT);
  localparam logic [CNT_DW-1:0] CNT_ONE = CNT_DW'(1);

  state_e            state_q, state_d;
  logic [CNT_DW-1:0] tgt_q, tgt_d;
  logic [CNT_DW-1:0] smp_q, smp_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [BIN_W-1:0]  res_bin_q, res_bin_d;
  logic              cfg_err_q, cfg_err_d;

  // State and datapath registers; reset returns everything to an idle, empty window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      smp_q     <= '0;
      set_q     <= '0;
      res_bin_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      smp_q     <= smp_d;
      set_q     <= set_d;
      res_bin_q <= res_bin_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state and handshake outputs; abort takes priority over start and samples.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    smp_d      = smp_q;
    set_d      = set_q;
    res_bin_d  = res_bin_q;
    cfg_err_d  = 1'b0;
    cnt_en     = 1'b0;
    peak_ready = 1'b0;
    res_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_num_samples == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            tgt_d   = cfg_num_samples;
            smp_d   = '0;
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        // A sample arriving together with abort must not reach the histogram.
        cnt_en = sample_valid & ~abort;
        if (abort) begin
          set_d   = '0;
          state_d = FLUSH;
        end else if (sample_valid) begin
          if (smp_q == tgt_q - CNT_ONE) begin
            set_d   = '0;
            state_d = SETTLE;
          end else begin
            smp_d = smp_q + CNT_ONE;
          end
        end
      end

      SETTLE: begin
        if (abort) begin
          set_d   = '0;
          state_d = FLUSH;
        end else if (set_q == SET_LAST) begin
          set_d   = '0;
          state_d = FETCH;
        end else begin
          set_d = set_q + SET_ONE;
        end
      end

      FETCH: begin
        peak_ready = 1'b1;
        if (peak_valid) begin
          if (abort) begin
            state_d = IDLE;
          end else begin
            res_bin_d = peak_bin;
            state_d   = OUTPUT;
          end
        end else if (abort) begin
          // Pipeline already drained: keep offering the clearing handshake.
          set_d   = SET_DONE;
          state_d = FLUSH;
        end
      end

      OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      FLUSH: begin
        if (set_q == SET_DONE) begin
          peak_ready = 1'b1;
          if (peak_valid) begin
            state_d = IDLE;
          end
        end else begin
          set_d = set_q + SET_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign res_bin = res_bin_q;
  assign cfg_err = cfg_err_q;

endmodule
